// File: rtl/mem_stage_access_ctrl_if.sv
// Bus bundle between the EX/MEM register, the MEM-stage access controller and the data cache.
// The controller takes the slave view; the pipeline/cache environment takes the master view.
interface mem_stage_access_ctrl_if;
  logic        dmemREN_EX_MEM;
  logic        dmemWEN_EX_MEM;
  logic [31:0] dmemaddr_EX_MEM;
  logic [31:0] dmemstore_EX_MEM;
  logic        halt_EX_MEM;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;

  modport slave (
    input  dmemREN_EX_MEM, dmemWEN_EX_MEM, dmemaddr_EX_MEM, dmemstore_EX_MEM, halt_EX_MEM,
    input  dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore
  );

  modport master (
    output dmemREN_EX_MEM, dmemWEN_EX_MEM, dmemaddr_EX_MEM, dmemstore_EX_MEM, halt_EX_MEM,
    output dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore
  );
endinterface

// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage data-cache access controller: one cache access per instruction, stall until dhit,
// load capture for MEM/WB, sticky halt, timeout flag and saturating stall/access counters.
module mem_stage_access_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 nRST,
  mem_stage_access_ctrl_if.slave bus,
  output logic                 stall_MEM,
  output logic [31:0]          load_data_MEM,
  output logic                 mem_done,
  output logic                 halt_out,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     access_cnt
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]      state_reg, state_next;
  logic            ren_reg, wen_reg;
  logic [31:0]     addr_reg, store_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic            mem_op;
  logic            in_req;

  assign mem_op = bus.dmemREN_EX_MEM | bus.dmemWEN_EX_MEM;
  assign in_req = (state_reg == REQ);

  // Request lines are only live in REQ so a held EX/MEM entry can never re-trigger the cache.
  assign bus.dmemREN   = in_req & ren_reg;
  assign bus.dmemWEN   = in_req & wen_reg;
  assign bus.dmemaddr  = in_req ? addr_reg  : 32'd0;
  assign bus.dmemstore = in_req ? store_reg : 32'd0;
  assign halt_out      = (state_reg == HALT);

  always_comb begin
    state_next = state_reg;
    stall_MEM  = 1'b0;
    mem_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Gated by nRST so the stall line is quiet while the block is held in reset.
        stall_MEM = nRST & mem_op & ~bus.halt_EX_MEM;
        if (bus.halt_EX_MEM)
          state_next = HALT;
        else if (mem_op)
          state_next = REQ;
      end
      REQ: begin
        stall_MEM = ~bus.dhit;
        if (bus.dhit)
          state_next = DONE;
      end
      DONE: begin
        mem_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = HALT;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg     <= IDLE;
      ren_reg       <= 1'b0;
      wen_reg       <= 1'b0;
      addr_reg      <= 32'd0;
      store_reg     <= 32'd0;
      load_data_MEM <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && !bus.halt_EX_MEM && mem_op) begin
        // A simultaneous read and write is issued as a write only.
        ren_reg   <= bus.dmemREN_EX_MEM & ~bus.dmemWEN_EX_MEM;
        wen_reg   <= bus.dmemWEN_EX_MEM;
        addr_reg  <= bus.dmemaddr_EX_MEM;
        store_reg <= bus.dmemstore_EX_MEM;
      end
      if (in_req && bus.dhit && ren_reg)
        load_data_MEM <= bus.dmemload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      to_cnt_reg  <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_reg == IDLE && state_next == REQ)
        to_cnt_reg <= '0;
      else if (in_req && !bus.dhit && to_cnt_reg != TO_MAX) begin
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
        if (to_cnt_reg == TO_LAST)
          timeout_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt  <= '0;
      access_cnt <= '0;
    end else begin
      if (stall_MEM && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (mem_done && access_cnt != '1)
        access_cnt <= access_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Bench for mem_stage_access_ctrl: table of accesses checked through an expected-result queue,
// plus hand-written halt, timeout and mid-access reset sequences.
module tb_mem_stage_access_ctrl;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 64;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             stall_MEM;
  logic [31:0]      load_data_MEM;
  logic             mem_done;
  logic             halt_out;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] access_cnt;

  mem_stage_access_ctrl_if bus();

  mem_stage_access_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .bus           (bus),
    .stall_MEM     (stall_MEM),
    .load_data_MEM (load_data_MEM),
    .mem_done      (mem_done),
    .halt_out      (halt_out),
    .timeout_err   (timeout_err),
    .stall_cnt     (stall_cnt),
    .access_cnt    (access_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] load_val;
    int          delay;
    int          exp_ren;
    int          exp_wen;
    int          exp_stall;
    logic [31:0] exp_load;
    int          exp_err;
  } vec_t;

  vec_t       vecs[5];
  vec_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [31:0] exp_stall_total;
  logic [31:0] exp_access_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else
      $display("ok   %s: 0x%0h", name, act);
  endtask

  task automatic idle_inputs();
    bus.dmemREN_EX_MEM   = 1'b0;
    bus.dmemWEN_EX_MEM   = 1'b0;
    bus.dmemaddr_EX_MEM  = 32'd0;
    bus.dmemstore_EX_MEM = 32'd0;
    bus.halt_EX_MEM      = 1'b0;
    bus.dhit             = 1'b0;
    bus.dmemload         = 32'd0;
  endtask

  task automatic run_vec(input vec_t v);
    int   req_seen, ren_c, wen_c, st_c, err_first, cyc;
    bit   done, unstable;
    logic requesting;
    vec_t e;
    @(posedge CLK); #1;
    bus.dhit             = 1'b0;
    bus.halt_EX_MEM      = 1'b0;
    bus.dmemREN_EX_MEM   = v.ren;
    bus.dmemWEN_EX_MEM   = v.wen;
    bus.dmemaddr_EX_MEM  = v.addr;
    bus.dmemstore_EX_MEM = v.data;
    exp_q.push_back(v);
    req_seen = 0; ren_c = 0; wen_c = 0; st_c = 0; err_first = -1; cyc = 0;
    done = 1'b0; unstable = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge CLK);
      requesting = bus.dmemREN | bus.dmemWEN;
      if (requesting && req_seen == v.delay) begin
        bus.dhit     = 1'b1;
        bus.dmemload = v.load_val;
      end
      #1;
      if (bus.dmemREN) ren_c++;
      if (bus.dmemWEN) wen_c++;
      if (stall_MEM)   st_c++;
      if (requesting && (bus.dmemaddr !== v.addr || bus.dmemstore !== v.data)) unstable = 1'b1;
      if (timeout_err && err_first < 0) err_first = req_seen;
      if (requesting) req_seen++;
      if (mem_done) begin
        done = 1'b1;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty: got mem_done expected no completion");
        end else begin
          e = exp_q.pop_front();
          exp_stall_total = exp_stall_total + 32'(e.exp_stall);
          check($sformatf("ren_cycles@%0h", e.addr), 32'(ren_c), 32'(e.exp_ren));
          check($sformatf("wen_cycles@%0h", e.addr), 32'(wen_c), 32'(e.exp_wen));
          check($sformatf("stall_cycles@%0h", e.addr), 32'(st_c), 32'(e.exp_stall));
          check($sformatf("addr_data_stable@%0h", e.addr), 32'(unstable), 32'd0);
          check($sformatf("done_quiet@%0h", e.addr),
                {29'd0, bus.dmemREN, bus.dmemWEN, stall_MEM}, 32'd0);
          check($sformatf("load_data@%0h", e.addr), load_data_MEM, e.exp_load);
          check($sformatf("stall_cnt@%0h", e.addr), stall_cnt, exp_stall_total);
          check($sformatf("access_cnt@%0h", e.addr), access_cnt, exp_access_total);
          check($sformatf("timeout_at@%0h", e.addr), 32'(err_first), 32'(e.exp_err));
          exp_access_total = exp_access_total + 32'd1;
        end
      end
      if (!done) begin
        @(posedge CLK); #1;
        bus.dhit = 1'b0;
        cyc++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_done@%0h: got no mem_done within %0d cycles expected mem_done", v.addr, cyc);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   bad;
    vec_t tv;
    exp_stall_total  = 32'd0;
    exp_access_total = 32'd0;
    // ren wen addr data load_val delay | exp_ren exp_wen exp_stall exp_load exp_err
    vecs[0] = '{1'b1, 1'b0, 32'h40,  32'h0,        32'hDEADBEEF, 0, 1, 0, 1, 32'hDEADBEEF, -1};
    vecs[1] = '{1'b0, 1'b1, 32'h80,  32'h12345678, 32'hFFFFFFFF, 5, 0, 6, 6, 32'hDEADBEEF, -1};
    vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'hCAFEF00D, 0, 1, 0, 1, 32'hCAFEF00D, -1};
    vecs[3] = '{1'b1, 1'b0, 32'h104, 32'h0,        32'h0BADF00D, 2, 3, 0, 3, 32'h0BADF00D, -1};
    vecs[4] = '{1'b1, 1'b1, 32'h200, 32'hA5A5A5A5, 32'h5555AAAA, 1, 0, 2, 2, 32'h0BADF00D, -1};

    idle_inputs();
    nRST = 1'b1;
    #2 nRST = 1'b0;
    #1;
    check("reset_req", {30'd0, bus.dmemREN, bus.dmemWEN}, 32'd0);
    check("reset_flags", {28'd0, stall_MEM, mem_done, halt_out, timeout_err}, 32'd0);
    check("reset_counts", stall_cnt | access_cnt | load_data_MEM | bus.dmemaddr, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) nRST = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Late dhit: flag must rise after exactly TIMEOUT waiting cycles and the access still completes.
    tv = '{1'b1, 1'b0, 32'h300, 32'h0, 32'h13579BDF, TIMEOUT + 2, TIMEOUT + 3, 0, TIMEOUT + 3,
           32'h13579BDF, TIMEOUT};
    run_vec(tv);
    @(posedge CLK); #1;
    idle_inputs();
    check("access_total", access_cnt, exp_access_total);
    check("timeout_sticky", 32'(timeout_err), 32'd1);

    // Reset in the middle of a request.
    @(posedge CLK); #1;
    bus.dmemREN_EX_MEM  = 1'b1;
    bus.dmemaddr_EX_MEM = 32'h400;
    bad = 0;
    while (!bus.dmemREN && bad < 5) begin
      @(negedge CLK); #1;
      bad++;
    end
    check("rst_mid_reached_req", 32'(bus.dmemREN), 32'd1);
    nRST = 1'b0;
    idle_inputs();
    #1;
    check("rst_mid_req", {30'd0, bus.dmemREN, bus.dmemWEN}, 32'd0);
    check("rst_mid_addr", bus.dmemaddr, 32'd0);
    check("rst_mid_flags", {28'd0, stall_MEM, mem_done, halt_out, timeout_err}, 32'd0);
    check("rst_mid_counts", stall_cnt | access_cnt, 32'd0);
    check("rst_mid_load", load_data_MEM, 32'd0);
    @(negedge CLK) nRST = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge CLK); #1;
      if (bus.dmemREN || bus.dmemWEN || stall_MEM || mem_done) bad++;
    end
    check("rst_no_reissue", 32'(bad), 32'd0);

    // Halt together with a store: nothing issued, halt sticks, later traffic ignored.
    @(posedge CLK); #1;
    bus.halt_EX_MEM      = 1'b1;
    bus.dmemWEN_EX_MEM   = 1'b1;
    bus.dmemaddr_EX_MEM  = 32'h500;
    bus.dmemstore_EX_MEM = 32'h77;
    @(negedge CLK); #1;
    check("halt_no_stall", 32'(stall_MEM), 32'd0);
    check("halt_not_yet", 32'(halt_out), 32'd0);
    @(posedge CLK); #1;
    bus.halt_EX_MEM     = 1'b0;
    bus.dmemWEN_EX_MEM  = 1'b0;
    bus.dmemREN_EX_MEM  = 1'b1;
    bus.dmemaddr_EX_MEM = 32'h600;
    check("halt_out_set", 32'(halt_out), 32'd1);
    bad = 0;
    repeat (8) begin
      @(negedge CLK);
      bus.dhit     = 1'b1;
      bus.dmemload = 32'hFFFF0000;
      #1;
      if (bus.dmemREN || bus.dmemWEN || stall_MEM || mem_done || !halt_out) bad++;
    end
    check("halt_ignores_ops", 32'(bad), 32'd0);
    check("halt_access_cnt", access_cnt, 32'd0);
    check("halt_load_kept", load_data_MEM, 32'd0);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
